// File: rtl/k_current_calc_if.sv
// Operand/result handshake bundle for the potassium-current stage.
// The slave modport is the calculator's view; the master modport is the producer/consumer view.
interface k_current_calc_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] n_in;
    logic signed [15:0] V_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] i_k;
    logic               sat;

    modport slave (
        input  in_valid, n_in, V_in, out_ready,
        output in_ready, out_valid, i_k, sat
    );

    modport master (
        output in_valid, n_in, V_in, out_ready,
        input  in_ready, out_valid, i_k, sat
    );
endinterface

// File: rtl/k_current_calc.sv
// Potassium current I_K = G_K * n^4 * (V - E_K), computed in four sequential steps
// that share one multiply/divide path, with a valid/ready handshake on each side.
module k_current_calc #(
    parameter logic signed [15:0] G_K   = 16'sd36,
    parameter logic signed [15:0] E_K   = -16'sd77,
    parameter int                 SCALE = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    k_current_calc_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SQ1   = 3'd1,
        SQ2   = 3'd2,
        GAIN  = 3'd3,
        DRIVE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic signed [15:0] SCALE_N = 16'(SCALE);
    localparam logic signed [31:0] SCALE_W = 32'(SCALE);
    localparam logic signed [31:0] G_K_W   = {{16{G_K[15]}}, G_K};

    state_t             state_q;
    logic        [15:0] n_c_q;
    logic signed [16:0] dv_q;
    logic signed [31:0] n2_q;
    logic signed [31:0] n4_q;
    logic signed [31:0] gn_q;
    logic signed [15:0] i_k_q;
    logic               sat_q;
    logic               out_valid_q;
    logic               in_ready_q;

    logic        [15:0] n_c_d;
    logic signed [16:0] dv_d;
    logic signed [31:0] n_c_w;
    logic signed [31:0] n2_d;
    logic signed [31:0] n4_d;
    logic signed [31:0] gn_d;
    logic signed [33:0] p_d;
    logic signed [15:0] i_k_d;
    logic               sat_d;

    // Shared datapath: clamp/offset of the operands and each step's product.
    always_comb begin
        n_c_d = 16'd0;
        if (bus.n_in < 16'sd0) begin
            n_c_d = 16'd0;
        end else if (bus.n_in > SCALE_N) begin
            n_c_d = SCALE_N;
        end else begin
            n_c_d = bus.n_in;
        end
        dv_d  = {bus.V_in[15], bus.V_in} - {E_K[15], E_K};
        n_c_w = {16'd0, n_c_q};
        n2_d  = (n_c_w * n_c_w) / SCALE_W;
        n4_d  = (n2_q * n2_q) / SCALE_W;
        gn_d  = (G_K_W * n4_q) / SCALE_W;
        p_d   = {{2{gn_q[31]}}, gn_q} * {{17{dv_q[16]}}, dv_q};
    end

    // Clip the 34-bit drive product into the 16-bit current range.
    always_comb begin
        i_k_d = 16'sd0;
        sat_d = 1'b0;
        if (p_d > 34'sd32767) begin
            i_k_d = 16'sh7FFF;
            sat_d = 1'b1;
        end else if (p_d < -34'sd32768) begin
            i_k_d = 16'sh8000;
            sat_d = 1'b1;
        end else begin
            i_k_d = p_d[15:0];
            sat_d = 1'b0;
        end
    end

    // Sequencer and all state/output registers; in_ready is registered to mirror IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            n_c_q       <= 16'd0;
            dv_q        <= 17'sd0;
            n2_q        <= 32'sd0;
            n4_q        <= 32'sd0;
            gn_q        <= 32'sd0;
            i_k_q       <= 16'sd0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        n_c_q      <= n_c_d;
                        dv_q       <= dv_d;
                        in_ready_q <= 1'b0;
                        state_q    <= SQ1;
                    end
                end
                SQ1: begin
                    n2_q    <= n2_d;
                    state_q <= SQ2;
                end
                SQ2: begin
                    n4_q    <= n4_d;
                    state_q <= GAIN;
                end
                GAIN: begin
                    gn_q    <= gn_d;
                    state_q <= DRIVE;
                end
                DRIVE: begin
                    i_k_q       <= i_k_d;
                    sat_q       <= sat_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.i_k       = i_k_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_k_current_calc.sv
// Self-checking bench: table of operand/expected pairs through a result queue, plus
// hand sequences for backpressure, large-gain saturation and mid-computation reset.
module tb_k_current_calc;
    logic clk;
    logic reset_n;
    logic               in_valid;
    logic signed [15:0] n_in;
    logic signed [15:0] V_in;
    logic               out_ready;
    logic               sel;

    k_current_calc_if bus_a ();
    k_current_calc_if bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.n_in      = n_in;
    assign bus_a.V_in      = V_in;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.n_in      = n_in;
    assign bus_b.V_in      = V_in;
    assign bus_b.out_ready = out_ready;

    k_current_calc dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    k_current_calc #(.G_K(16'sd10000)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    logic               o_in_ready;
    logic               o_out_valid;
    logic signed [15:0] o_i_k;
    logic               o_sat;
    assign o_in_ready  = sel ? bus_b.in_ready  : bus_a.in_ready;
    assign o_out_valid = sel ? bus_b.out_valid : bus_a.out_valid;
    assign o_i_k       = sel ? bus_b.i_k       : bus_a.i_k;
    assign o_sat       = sel ? bus_b.sat       : bus_a.sat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] n;
        logic signed [15:0] v;
        logic signed [15:0] ik;
        logic               sat;
    } vec_t;

    typedef struct {
        logic signed [15:0] ik;
        logic               sat;
    } exp_t;

    vec_t vecs [10];
    exp_t sb_q [$];
    int checks;
    int errors;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one operand pair and wait (bounded) for the accepting edge.
    task automatic accept(input logic signed [15:0] n, input logic signed [15:0] v,
                          input logic signed [15:0] ik, input logic s);
        int k;
        exp_t e;
        k = 0;
        while (!o_in_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("in_ready_wait", int'(o_in_ready), 1);
        in_valid = 1'b1;
        n_in     = n;
        V_in     = v;
        @(posedge clk);
        e.ik = ik;
        e.sat = s;
        sb_q.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    // Full transaction with latency check, optional backpressure and scoreboard pop.
    task automatic do_txn(input logic signed [15:0] n, input logic signed [15:0] v,
                          input logic signed [15:0] ik, input logic s, input int hold);
        int k;
        exp_t e;
        accept(n, v, ik, s);
        k = 0;
        while (!o_out_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", k, 4);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_out_valid", int'(o_out_valid), 1);
            check("bp_i_k", int'(o_i_k), int'(ik));
            check("bp_in_ready", int'(o_in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        if (o_out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("i_k", int'(o_i_k), int'(e.ik));
                check("sat", int'(o_sat), int'(e.sat));
            end
        end else begin
            check("out_valid", int'(o_out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_hs", int'(o_in_ready), 1);
        check("out_valid_clr", int'(o_out_valid), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sel = 1'b0;
        in_valid = 1'b0;
        n_in = 16'sd0;
        V_in = 16'sd0;
        out_ready = 1'b0;

        vecs[0] = '{n: 16'sd1000, v: 16'sd0,     ik: 16'sd2772, sat: 1'b0};
        vecs[1] = '{n: 16'sd2,    v: -16'sd65,   ik: 16'sd0,    sat: 1'b0};
        vecs[2] = '{n: 16'sd500,  v: -16'sd65,   ik: 16'sd24,   sat: 1'b0};
        vecs[3] = '{n: 16'sd1000, v: -16'sd77,   ik: 16'sd0,    sat: 1'b0};
        vecs[4] = '{n: -16'sd5,   v: 16'sd40,    ik: 16'sd0,    sat: 1'b0};
        vecs[5] = '{n: 16'sd800,  v: 16'sd20,    ik: 16'sd1358, sat: 1'b0};
        vecs[6] = '{n: 16'sd1200, v: 16'sd0,     ik: 16'sd2772, sat: 1'b0};
        vecs[7] = '{n: 16'sd1000, v: -16'sd100,  ik: -16'sd828, sat: 1'b0};
        vecs[8] = '{n: 16'sd1000, v: 16'sd32767, ik: 16'sd32767, sat: 1'b1};
        vecs[9] = '{n: 16'sd1000, v: 16'sd800,   ik: 16'sd31572, sat: 1'b0};

        reset_n = 1'b0;
        #12;
        check("rst_in_ready", int'(o_in_ready), 1);
        check("rst_out_valid", int'(o_out_valid), 0);
        check("rst_i_k", int'(o_i_k), 0);
        check("rst_sat", int'(o_sat), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i].n, vecs[i].v, vecs[i].ik, vecs[i].sat, 0);
        end

        do_txn(16'sd1000, 16'sd0, 16'sd2772, 1'b0, 10);

        sel = 1'b1;
        do_txn(16'sd1500, 16'sd32767, 16'sd32767, 1'b1, 0);
        do_txn(16'sd1500, -16'sd32768, -16'sd32768, 1'b1, 0);
        sel = 1'b0;

        accept(16'sd1000, 16'sd0, 16'sd2772, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", int'(o_out_valid), 0);
        check("abort_i_k", int'(o_i_k), 0);
        check("abort_in_ready", int'(o_in_ready), 1);
        void'(sb_q.pop_back());
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_txn(16'sd500, -16'sd65, 16'sd24, 1'b0, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
